// File: rtl/motoro_ramp_ctrl.sv
// Speed/direction ramp sequencer for the 3-phase PWM generator.
// Ramps m3freq linearly and only flips direction while stopped.
module motoro_ramp_ctrl #(
    parameter int FW          = 10,
    parameter int TICK_DIV    = 50000,
    parameter int STEP        = 1,
    parameter int FMIN        = 10,
    parameter int FMAX        = 1000,
    parameter int DWELL_TICKS = 200
) (
    input  logic          clk50mhz,
    input  logic          nReset,
    input  logic          cmdValid,
    output logic          cmdReady,
    input  logic [FW-1:0] cmdFreq,
    input  logic          cmdDir,
    input  logic          cmdStop,
    output logic          m3start,
    output logic [FW-1:0] m3freq,
    output logic          m3invOrStop,
    output logic          atSpeed,
    output logic          busy
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [FW-1:0] F_MIN      = FW'(FMIN);
    localparam logic [FW-1:0] F_MAX      = FW'(FMAX);
    localparam logic [FW:0]   F_STEP     = (FW + 1)'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        RUN,
        DOWN,
        DWELL
    } state_t;

    state_t        state;
    state_t        nst;
    logic [CW-1:0] tick_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] ndwell;
    logic [FW-1:0] target;
    logic [FW-1:0] ntgt;
    logic [FW-1:0] nfreq;
    logic [FW-1:0] clamp_freq;
    logic [FW-1:0] floor_freq;
    logic [FW:0]   up_sum;
    logic [FW:0]   dn_lim;
    logic          stop_pend;
    logic          rev_pend;
    logic          dwell_done;
    logic          nstop;
    logic          nrev;
    logic          ndone;
    logic          nstart;
    logic          ninv;
    logic          pend;
    logic          tick;
    logic          accept;

    assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign accept = cmdValid && cmdReady;

    always_comb begin
        clamp_freq = cmdFreq;
        if (cmdFreq < F_MIN) begin
            clamp_freq = F_MIN;
        end else if (cmdFreq > F_MAX) begin
            clamp_freq = F_MAX;
        end
    end

    always_comb begin
        nst        = state;
        ntgt       = target;
        nfreq      = m3freq;
        nstart     = m3start;
        ninv       = m3invOrStop;
        nstop      = stop_pend;
        nrev       = rev_pend;
        ndwell     = dwell_cnt;
        ndone      = dwell_done;
        pend       = 1'b0;
        floor_freq = target;
        up_sum     = '0;
        dn_lim     = '0;
        unique case (state)
            IDLE: begin
                if (accept && !cmdStop) begin
                    nst    = UP;
                    nstart = 1'b1;
                    nfreq  = F_MIN;
                    ninv   = cmdDir;
                    ntgt   = clamp_freq;
                    nstop  = 1'b0;
                    nrev   = 1'b0;
                end
            end
            DWELL: begin
                if (dwell_done) begin
                    nst    = UP;
                    nstart = 1'b1;
                    nfreq  = F_MIN;
                    nrev   = 1'b0;
                    ndone  = 1'b0;
                    ndwell = '0;
                end else if (tick) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        ninv  = ~m3invOrStop;
                        ndone = 1'b1;
                    end else begin
                        ndwell = dwell_cnt + DW'(1);
                    end
                end
            end
            default: begin
                // The command lands first so a coincident tick steps toward it
                if (accept) begin
                    if (cmdStop) begin
                        nstop = 1'b1;
                        nrev  = 1'b0;
                    end else begin
                        ntgt  = clamp_freq;
                        nstop = 1'b0;
                        nrev  = (cmdDir != m3invOrStop);
                    end
                end
                pend       = nstop | nrev;
                floor_freq = pend ? F_MIN : ntgt;
                up_sum     = {1'b0, m3freq} + F_STEP;
                dn_lim     = {1'b0, floor_freq} + F_STEP;
                if (pend) begin
                    nst = DOWN;
                    if (tick) begin
                        if (m3freq <= F_MIN) begin
                            nstart = 1'b0;
                            nfreq  = '0;
                            if (nstop) begin
                                nst   = IDLE;
                                nstop = 1'b0;
                            end else begin
                                nst    = DWELL;
                                ndwell = '0;
                                ndone  = 1'b0;
                            end
                        end else if ({1'b0, m3freq} >= dn_lim) begin
                            nfreq = m3freq - F_STEP[FW-1:0];
                        end else begin
                            nfreq = F_MIN;
                        end
                    end
                end else begin
                    if (tick) begin
                        if (m3freq < ntgt) begin
                            if (up_sum >= {1'b0, ntgt}) begin
                                nfreq = ntgt;
                            end else begin
                                nfreq = up_sum[FW-1:0];
                            end
                        end else if (m3freq > ntgt) begin
                            if ({1'b0, m3freq} >= dn_lim) begin
                                nfreq = m3freq - F_STEP[FW-1:0];
                            end else begin
                                nfreq = ntgt;
                            end
                        end
                    end
                    if (nfreq < ntgt) begin
                        nst = UP;
                    end else if (nfreq == ntgt) begin
                        nst = RUN;
                    end else begin
                        nst = DOWN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            dwell_cnt   <= '0;
            target      <= '0;
            stop_pend   <= 1'b0;
            rev_pend    <= 1'b0;
            dwell_done  <= 1'b0;
            m3start     <= 1'b0;
            m3freq      <= '0;
            m3invOrStop <= 1'b0;
            atSpeed     <= 1'b0;
            busy        <= 1'b0;
            cmdReady    <= 1'b1;
        end else begin
            state       <= nst;
            dwell_cnt   <= ndwell;
            target      <= ntgt;
            stop_pend   <= nstop;
            rev_pend    <= nrev;
            dwell_done  <= ndone;
            m3start     <= nstart;
            m3freq      <= nfreq;
            m3invOrStop <= ninv;
            atSpeed     <= (nst == RUN);
            busy        <= (nst != IDLE);
            cmdReady    <= (nst != DWELL);
            if (state == IDLE || nst == IDLE || tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_motoro_ramp_ctrl.sv
// Randomised and directed bench for motoro_ramp_ctrl.
// A behavioural ramp model feeds a change-driven output scoreboard.
module tb_motoro_ramp_ctrl;

    localparam int FW          = 10;
    localparam int TICK_DIV    = 4;
    localparam int STEP        = 5;
    localparam int FMIN        = 10;
    localparam int FMAX        = 100;
    localparam int DWELL_TICKS = 3;

    logic          clk      = 1'b0;
    logic          nReset   = 1'b1;
    logic          cmdValid = 1'b0;
    logic          cmdDir   = 1'b0;
    logic          cmdStop  = 1'b0;
    logic [FW-1:0] cmdFreq  = '0;
    logic          cmdReady;
    logic          m3start;
    logic [FW-1:0] m3freq;
    logic          m3invOrStop;
    logic          atSpeed;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          start;
        logic [FW-1:0] freq;
        logic          inv;
        logic          at;
        logic          bsy;
        logic          rdy;
    } obs_t;

    typedef struct {
        obs_t v;
        int   stamp;
    } exp_t;

    localparam obs_t RESET_OBS = '{start: 1'b0, freq: '0, inv: 1'b0,
                                   at: 1'b0, bsy: 1'b0, rdy: 1'b1};

    exp_t sbq[$];
    int   mcyc = 0;

    always #5 clk = ~clk;

    motoro_ramp_ctrl #(
        .FW(FW),
        .TICK_DIV(TICK_DIV),
        .STEP(STEP),
        .FMIN(FMIN),
        .FMAX(FMAX),
        .DWELL_TICKS(DWELL_TICKS)
    ) dut (
        .clk50mhz(clk),
        .nReset(nReset),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdFreq(cmdFreq),
        .cmdDir(cmdDir),
        .cmdStop(cmdStop),
        .m3start(m3start),
        .m3freq(m3freq),
        .m3invOrStop(m3invOrStop),
        .atSpeed(atSpeed),
        .busy(busy)
    );

    // Behavioural model: motor is running, dwelling or off
    bit running, dwelling, relaunch, launched, want_stop, want_rev, dir;
    int freq, goal, ph, dwell_left;

    function automatic obs_t model_obs();
        obs_t o;
        o.start = running;
        o.freq  = FW'(freq);
        o.inv   = dir;
        o.at    = running && !want_stop && !want_rev && freq == goal && !launched;
        o.bsy   = running || dwelling;
        o.rdy   = !dwelling;
        return o;
    endfunction

    initial begin
        obs_t m_last;
        obs_t cur;
        bit   was_idle;
        bit   tk;
        int   g;
        m_last = RESET_OBS;
        forever begin
            @(posedge clk or negedge nReset);
            if (!nReset) begin
                running = 0; dwelling = 0; relaunch = 0; launched = 0;
                want_stop = 0; want_rev = 0; dir = 0;
                freq = 0; goal = 0; ph = 0; dwell_left = 0;
            end else begin
                was_idle = !running && !dwelling;
                tk       = !was_idle && ph == TICK_DIV - 1;
                launched = 0;
                if (cmdValid && !dwelling) begin
                    g = int'(cmdFreq);
                    g = g < FMIN ? FMIN : (g > FMAX ? FMAX : g);
                    if (was_idle) begin
                        if (!cmdStop) begin
                            running = 1; freq = FMIN; dir = cmdDir; goal = g;
                            want_stop = 0; want_rev = 0; launched = 1;
                        end
                    end else if (cmdStop) begin
                        want_stop = 1; want_rev = 0;
                    end else begin
                        goal = g; want_stop = 0; want_rev = (cmdDir != dir);
                    end
                end
                if (running && !launched) begin
                    if (tk) begin
                        if (want_stop || want_rev) begin
                            if (freq <= FMIN) begin
                                running = 0; freq = 0;
                                if (want_stop) begin
                                    want_stop = 0;
                                end else begin
                                    want_rev = 0; dwelling = 1;
                                    dwell_left = DWELL_TICKS;
                                end
                            end else begin
                                freq = (freq - STEP > FMIN) ? freq - STEP : FMIN;
                            end
                        end else if (freq < goal) begin
                            freq = (freq + STEP < goal) ? freq + STEP : goal;
                        end else if (freq > goal) begin
                            freq = (freq - STEP > goal) ? freq - STEP : goal;
                        end
                    end
                end else if (dwelling) begin
                    if (relaunch) begin
                        relaunch = 0; dwelling = 0; running = 1;
                        freq = FMIN; launched = 1;
                    end else if (tk) begin
                        dwell_left--;
                        if (dwell_left == 0) begin
                            dir = !dir; relaunch = 1;
                        end
                    end
                end
                if (was_idle || (!running && !dwelling)) ph = 0;
                else ph = (ph == TICK_DIV - 1) ? 0 : ph + 1;
            end
            cur = model_obs();
            if (cur != m_last) begin
                sbq.push_back('{v: cur, stamp: mcyc});
                m_last = cur;
            end
        end
    end

    // Monitor: every observed output change must match the next expected one
    always @(negedge clk) begin
        obs_t cur;
        obs_t dut_last;
        exp_t e;
        if (mcyc == 0) dut_last = RESET_OBS;
        cur = {m3start, m3freq, m3invOrStop, atSpeed, busy, cmdReady};
        while (sbq.size() > 0 && sbq[0].stamp < mcyc) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missed: cyc %0d expected %h at cyc %0d, dut %h",
                     mcyc, e.v, e.stamp, cur);
        end
        if (cur !== dut_last) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: cyc %0d dut %h, required %h",
                         mcyc, cur, dut_last);
            end else begin
                e = sbq.pop_front();
                if (e.v !== cur || e.stamp != mcyc) begin
                    errors++;
                    $display("FAIL sb_change: cyc %0d dut %h, required %h at cyc %0d",
                             mcyc, cur, e.v, e.stamp);
                end
            end
            dut_last = cur;
        end
        mcyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic pulse_cmd(input int f, input bit d, input bit s);
        cmdValid = 1'b1;
        cmdFreq  = FW'(f);
        cmdDir   = d;
        cmdStop  = s;
        @(negedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic send_cmd(input int f, input bit d, input bit s);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!cmdReady && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!cmdReady) begin
            errors++;
            $display("FAIL ready_wait: cmdReady 0 after %0d cycles, required 1", n);
        end
        pulse_cmd(f, d, s);
    endtask

    // what: 0 atSpeed, 1 idle, 2 freq==val, 3 !cmdReady, 4 atSpeed with inv==val
    task automatic wait_for(input string name, input int what, input int val,
                            input int budget);
        int n;
        bit ok;
        logic [31:0] v;
        n  = 0;
        ok = 0;
        v  = val;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            case (what)
                0:       ok = atSpeed;
                1:       ok = !busy;
                2:       ok = (m3freq == FW'(val));
                3:       ok = !cmdReady;
                default: ok = atSpeed && (m3invOrStop == v[0]);
            endcase
            n++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: condition 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    initial begin
        #1 nReset = 1'b0;
        #2;
        chk("rst_start", m3start, 0);
        chk("rst_freq", m3freq, 0);
        chk("rst_inv", m3invOrStop, 0);
        chk("rst_at", atSpeed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmdReady, 1);
        repeat (2) @(negedge clk);
        #1 nReset = 1'b1;

        send_cmd(30, 0, 0);
        chk("t1_start", m3start, 1);
        chk("t1_fmin", m3freq, 10);
        wait_for("t1_at", 0, 0, 200);
        chk("t1_freq", m3freq, 30);

        send_cmd(0, 0, 1);
        wait_for("t2_idle", 1, 0, 200);
        chk("t2_start", m3start, 0);
        chk("t2_freq", m3freq, 0);
        chk("t2_inv", m3invOrStop, 0);

        send_cmd(30, 0, 0);
        wait_for("t3_at30", 0, 0, 200);
        send_cmd(20, 1, 0);
        wait_for("t3_dwell", 3, 0, 200);
        pulse_cmd(80, 0, 0);
        chk("t3_inv_dwell", m3invOrStop, 0);
        chk("t3_off_dwell", m3start, 0);
        wait_for("t3_rev", 4, 1, 300);
        chk("t3_freq", m3freq, 20);

        send_cmd(500, 1, 0);
        wait_for("t4_at", 0, 0, 300);
        chk("t4_clamp", m3freq, 100);
        send_cmd(0, 0, 1);
        wait_for("t4_idle", 1, 0, 400);
        send_cmd(3, 1, 0);
        wait_for("t4_at_min", 0, 0, 50);
        chk("t4_min", m3freq, 10);
        send_cmd(0, 0, 1);
        wait_for("t4_idle2", 1, 0, 100);

        send_cmd(50, 0, 0);
        wait_for("t5_20", 2, 20, 100);
        send_cmd(15, 0, 0);
        wait_for("t5_at", 0, 0, 100);
        chk("t5_freq", m3freq, 15);

        send_cmd(50, 0, 0);
        wait_for("t6_at", 0, 0, 300);
        send_cmd(0, 0, 1);
        wait_for("t6_25", 2, 25, 200);
        #1 nReset = 1'b0;
        #1;
        chk("t6_start", m3start, 0);
        chk("t6_freq", m3freq, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmdReady, 1);
        @(negedge clk); #1 nReset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("t6_stay_idle", busy, 0);
        chk("t6_stay_off", m3start, 0);

        for (int i = 0; i < 40; i++) begin
            int f;
            f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                            : int'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) pulse_cmd(f, 1'($urandom), 1'b1);
            else pulse_cmd(f, 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 60)) @(negedge clk);
            #1;
        end
        send_cmd(0, 0, 1);
        wait_for("rnd_idle", 1, 0, 600);
        repeat (5) @(negedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
